multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle control unit for the RV32I-subset core. It sits on the other side of the datapath's control interface: it sequences each instruction through IF/ID/EX/MEM/WB and drives PCSrc, ALUSrc, RegWrite, MemToReg, loadPC and ALUCtrl into the datapath. It also drives MemRead/MemWrite strobes to data memory. Inputs are the fetched instruction word and the datapath Zero flag.

Parameters:
MEM_WAIT, 0, number of extra cycles held in MEM (0..15) before the memory access completes; 4-bit internal counter.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
instr  input  32  current instruction word, stable from IF through end of instruction
Zero  input  1  datapath ALU zero flag
PCSrc  output  1  1 = branch target, 0 = PC+4; only meaningful while loadPC=1
ALUSrc  output  1  1 = immediate operand, 0 = register operand
RegWrite  output  1  register-file write enable
MemToReg  output  1  1 = write back memory data, 0 = ALU result
loadPC  output  1  PC update strobe, exactly one cycle per instruction
MemRead  output  1  data-memory read strobe
MemWrite  output  1  data-memory write strobe
ALUCtrl  output  4  ALU operation code
illegal  output  1  one-cycle pulse in the ID cycle of an undecodable instruction

Behaviour:
- One clock. Reset is asynchronous and active-low. With rst=0: state=IF, wait counter=0, and all outputs are 0, including ALUCtrl=4'b0000. Reset asserted mid-instruction aborts it immediately; no loadPC, RegWrite or MemWrite follows.
- States: IF, ID, EX, MEM, WB, encoded as a 3-bit registered state.
- IF: all strobes 0. Next state is ID.
- ID: decode opcode instr[6:0], funct3 instr[14:12] and funct7 instr[31:25]. Register ALUSrc and ALUCtrl at the ID->EX edge. Both hold their values until the edge that enters IF.
- Illegal instruction in ID: pulse illegal, go to IF, and do not assert loadPC. The PC does not advance, so software or the bench must intervene.
- EX: no strobes.
  - R-type (0110011) and I-type ALU (0010011) go to WB.
  - LW (0000011), SW (0100011) and BEQ (1100011) go to MEM.
- MEM:
  - LW: MemRead=1 in every MEM cycle.
  - SW: MemWrite=1 only in the final MEM cycle. In that cycle also loadPC=1, PCSrc=0, then go to IF.
  - BEQ: loadPC=1 and PCSrc=Zero in the final MEM cycle, then go to IF.
  - LW: go to WB after the final MEM cycle.
  - MEM lasts 1+MEM_WAIT cycles. The counter clears on MEM entry.
- WB: RegWrite=1 and loadPC=1 with PCSrc=0. MemToReg=1 for LW, else 0. Next state is IF.
- Latency in cycles: R/I = 4; BEQ and SW = 4+MEM_WAIT; LW = 5+MEM_WAIT.
- RegWrite, MemRead, MemWrite and loadPC are decoded combinationally from the registered state and instruction class. They are never asserted outside the states listed above.
- ALUCtrl encoding: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, SRL=1000, SLL=1001, SRA=1010, XOR=1101.
- R-type decode (funct3):
  - 000: ADD if funct7=0000000, SUB if 0100000
  - 001: SLL; 010: SLT; 100: XOR
  - 101: SRL if funct7=0000000, SRA if 0100000
  - 110: OR; 111: AND
  - funct7 other than 0000000 is illegal, except 0100000 with funct3 000 or 101.
- I-type ALU decode: ADDI, SLTI, XORI, ORI and ANDI by funct3. SLLI requires funct7=0. Funct3 101 gives SRLI/SRAI by funct7. funct3 011 (SLTIU) is illegal.
- LW and SW: ALUCtrl=ADD, ALUSrc=1, funct3 must be 010. BEQ: ALUCtrl=SUB, ALUSrc=0, funct3 must be 000. Any other opcode is illegal.
- ALUSrc=1 for I-type, LW and SW; 0 for R-type and BEQ.

Optional Feature:
Macro CTRL_PERF_EN.
- Defined: adds output ports instret[31:0] and cycles[31:0]. instret increments on every loadPC=1 cycle. cycles increments every cycle out of reset. Both wrap 0xFFFFFFFF->0 and reset to 0.
- Undefined: neither the ports nor the counters exist.

Test Plan:
- Reset: rst=0 mid-EX of an ADD -> all outputs 0 immediately (before the next clock edge). After release, IF, then ID one cycle later. No RegWrite pulse.
- ADD x3,x1,x2 (0x002081B3) -> ALUCtrl=0010, ALUSrc=0. RegWrite and loadPC high only in cycle 4, PCSrc=0.
- LW x5,8(x1) (0x0080A283), MEM_WAIT=2 -> MemRead high in cycles 4-6. Cycle 7: RegWrite=1, MemToReg=1, loadPC=1.
- BEQ, Zero=1 then Zero=0 -> in cycle 4, loadPC=1 with PCSrc=1, then PCSrc=0. RegWrite=0 and MemWrite=0 throughout.
- SRAI x2,x2,3 (0x40315113) -> ALUCtrl=1010, ALUSrc=1. 0x00000000 -> illegal pulse in cycle 2, loadPC never asserted.
- With CTRL_PERF_EN: three instructions (ADD, SW, BEQ), MEM_WAIT=0 -> instret=3, cycles=12.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between multicycle_ctrl (master) and the RV32I datapath (slave).
// Optional performance counters appear only when CTRL_PERF_EN is defined.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        Zero;
    logic        PCSrc;
    logic        ALUSrc;
    logic        RegWrite;
    logic        MemToReg;
    logic        loadPC;
    logic        MemRead;
    logic        MemWrite;
    logic [3:0]  ALUCtrl;
    logic        illegal;
`ifdef CTRL_PERF_EN
    logic [31:0] instret;
    logic [31:0] cycles;
`endif

    modport master (
        input  instr, Zero,
        output PCSrc, ALUSrc, RegWrite, MemToReg, loadPC,
        output MemRead, MemWrite, ALUCtrl, illegal
`ifdef CTRL_PERF_EN
        , output instret, cycles
`endif
    );

    modport slave (
        output instr, Zero,
        input  PCSrc, ALUSrc, RegWrite, MemToReg, loadPC,
        input  MemRead, MemWrite, ALUCtrl, illegal
`ifdef CTRL_PERF_EN
        , input instret, cycles
`endif
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB control unit for the RV32I-subset core.
// Define CTRL_PERF_EN to add the instret/cycles performance counters.
module multicycle_ctrl #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic           clk,
    input  logic           rst,
    multicycle_ctrl_if.master ctrl
);
    localparam int unsigned WAIT_W = 4;

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [1:0] CLS_ALU = 2'd0;
    localparam logic [1:0] CLS_LW  = 2'd1;
    localparam logic [1:0] CLS_SW  = 2'd2;
    localparam logic [1:0] CLS_BEQ = 2'd3;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    logic [2:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        cls_q;
    logic              alu_src_q;
    logic [3:0]        alu_ctrl_q;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       dec_legal, dec_src;
    logic [3:0] dec_alu;
    logic [1:0] dec_cls;

    logic pc_src_c, reg_write_c, mem_to_reg_c, load_pc_c;
    logic mem_read_c, mem_write_c, illegal_c, mem_last;

    // Register/rd fields are consumed by the datapath, not by control.
    logic unused_fields;
    assign unused_fields = ^{ctrl.instr[24:15], ctrl.instr[11:7]};

    assign opcode = ctrl.instr[6:0];
    assign funct3 = ctrl.instr[14:12];
    assign funct7 = ctrl.instr[31:25];

    // Instruction decode: legality, instruction class and ALU setup.
    always_comb begin
        dec_legal = 1'b0;
        dec_src   = 1'b0;
        dec_alu   = ALU_AND;
        dec_cls   = CLS_ALU;
        case (opcode)
            OP_R: begin
                case (funct3)
                    3'b000: begin
                        dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                        dec_alu   = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    end
                    3'b001: begin dec_legal = (funct7 == F7_ZERO); dec_alu = ALU_SLL; end
                    3'b010: begin dec_legal = (funct7 == F7_ZERO); dec_alu = ALU_SLT; end
                    3'b100: begin dec_legal = (funct7 == F7_ZERO); dec_alu = ALU_XOR; end
                    3'b101: begin
                        dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                        dec_alu   = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    end
                    3'b110: begin dec_legal = (funct7 == F7_ZERO); dec_alu = ALU_OR; end
                    3'b111: begin dec_legal = (funct7 == F7_ZERO); dec_alu = ALU_AND; end
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_I: begin
                dec_src = 1'b1;
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_alu = ALU_ADD; end
                    3'b001: begin dec_legal = (funct7 == F7_ZERO); dec_alu = ALU_SLL; end
                    3'b010: begin dec_legal = 1'b1; dec_alu = ALU_SLT; end
                    3'b100: begin dec_legal = 1'b1; dec_alu = ALU_XOR; end
                    3'b101: begin
                        dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                        dec_alu   = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    end
                    3'b110: begin dec_legal = 1'b1; dec_alu = ALU_OR; end
                    3'b111: begin dec_legal = 1'b1; dec_alu = ALU_AND; end
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_LW: begin
                dec_legal = (funct3 == 3'b010);
                dec_src   = 1'b1;
                dec_alu   = ALU_ADD;
                dec_cls   = CLS_LW;
            end
            OP_SW: begin
                dec_legal = (funct3 == 3'b010);
                dec_src   = 1'b1;
                dec_alu   = ALU_ADD;
                dec_cls   = CLS_SW;
            end
            OP_BEQ: begin
                dec_legal = (funct3 == 3'b000);
                dec_alu   = ALU_SUB;
                dec_cls   = CLS_BEQ;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign mem_last = (wait_q == WAIT_W'(MEM_WAIT));

    // Next-state and strobe decode from the registered state and class.
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        pc_src_c     = 1'b0;
        reg_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        load_pc_c    = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        illegal_c    = 1'b0;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (dec_legal) begin
                    state_d = S_EX;
                end else begin
                    illegal_c = 1'b1;
                    state_d   = S_IF;
                end
            end
            S_EX: begin
                if (cls_q == CLS_ALU) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end
            end
            S_MEM: begin
                if (!mem_last) wait_d = wait_q + WAIT_W'(1);
                case (cls_q)
                    CLS_LW: begin
                        mem_read_c = 1'b1;
                        if (mem_last) state_d = S_WB;
                    end
                    CLS_SW: begin
                        if (mem_last) begin
                            mem_write_c = 1'b1;
                            load_pc_c   = 1'b1;
                            state_d     = S_IF;
                        end
                    end
                    CLS_BEQ: begin
                        if (mem_last) begin
                            load_pc_c = 1'b1;
                            pc_src_c  = ctrl.Zero;
                            state_d   = S_IF;
                        end
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_WB: begin
                reg_write_c  = 1'b1;
                load_pc_c    = 1'b1;
                mem_to_reg_c = (cls_q == CLS_LW);
                state_d      = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IF;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // ALU setup is captured leaving ID and dropped when the instruction retires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cls_q      <= CLS_ALU;
            alu_src_q  <= 1'b0;
            alu_ctrl_q <= ALU_AND;
        end else if (state_q == S_ID && dec_legal) begin
            cls_q      <= dec_cls;
            alu_src_q  <= dec_src;
            alu_ctrl_q <= dec_alu;
        end else if (state_d == S_IF) begin
            cls_q      <= CLS_ALU;
            alu_src_q  <= 1'b0;
            alu_ctrl_q <= ALU_AND;
        end
    end

    assign ctrl.PCSrc    = pc_src_c;
    assign ctrl.ALUSrc   = alu_src_q;
    assign ctrl.RegWrite = reg_write_c;
    assign ctrl.MemToReg = mem_to_reg_c;
    assign ctrl.loadPC   = load_pc_c;
    assign ctrl.MemRead  = mem_read_c;
    assign ctrl.MemWrite = mem_write_c;
    assign ctrl.ALUCtrl  = alu_ctrl_q;
    assign ctrl.illegal  = illegal_c;

`ifdef CTRL_PERF_EN
    logic [31:0] instret_q, cycles_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_q <= '0;
            cycles_q  <= '0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
            if (load_pc_c) instret_q <= instret_q + 32'd1;
        end
    end

    assign ctrl.instret = instret_q;
    assign ctrl.cycles  = cycles_q;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: two instances, MEM_WAIT=0 and MEM_WAIT=2.
// Outputs are packed as {PCSrc,ALUSrc,RegWrite,MemToReg,loadPC,MemRead,MemWrite,ALUCtrl,illegal}.
module tb_multicycle_ctrl;
    logic clk;
    logic rst;

    multicycle_ctrl_if if0 ();
    multicycle_ctrl_if if2 ();

    multicycle_ctrl #(.MEM_WAIT(0)) u0 (.clk(clk), .rst(rst), .ctrl(if0));
    multicycle_ctrl #(.MEM_WAIT(2)) u2 (.clk(clk), .rst(rst), .ctrl(if2));

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SRAI = 32'h40315113;
    localparam logic [31:0] I_LW   = 32'h0080A283;
    localparam logic [31:0] I_SW   = 32'h0020A423;
    localparam logic [31:0] I_BEQ  = 32'h00208063;

    logic [11:0] o0, o2;
    assign o0 = {if0.PCSrc, if0.ALUSrc, if0.RegWrite, if0.MemToReg, if0.loadPC,
                 if0.MemRead, if0.MemWrite, if0.ALUCtrl, if0.illegal};
    assign o2 = {if2.PCSrc, if2.ALUSrc, if2.RegWrite, if2.MemToReg, if2.loadPC,
                 if2.MemRead, if2.MemWrite, if2.ALUCtrl, if2.illegal};

    int pass_cnt = 0;
    int total_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] ins, input logic z);
        if0.instr = ins;
        if2.instr = ins;
        if0.Zero  = z;
        if2.Zero  = z;
    endtask

    // Leaves both instances in IF at a falling edge (cycle 1 of the next instruction).
    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] exp_a [5];
        exp_a = '{12'h000, 12'h000, 12'h004, 12'h284, 12'h000};
        rst = 1'b0;
        drive(I_ADD, 1'b0);
        step();
        total_cnt++;
        if (o0 !== 12'h000 || o2 !== 12'h000)
            $display("FAIL reset_state: got %h/%h want 000", o0, o2);
        else pass_cnt++;
        rst = 1'b1;
        step();
        step();
        total_cnt++;
        if (o0 !== 12'h004) $display("FAIL reset_pre_ex: got %h want 004", o0);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (o0 !== 12'h000 || o2 !== 12'h000)
            $display("FAIL reset_abort_ex: got %h/%h want 000", o0, o2);
        else pass_cnt++;
        step();
        total_cnt++;
        if (o0 !== 12'h000) $display("FAIL reset_held: got %h want 000", o0);
        else pass_cnt++;
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            total_cnt++;
            if (o0 !== exp_a[c]) $display("FAIL reset_restart cyc%0d: got %h want %h", c + 1, o0, exp_a[c]);
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_alu();
        logic [31:0] ins [3];
        logic [11:0] ex_ex [3];
        logic [11:0] ex_wb [3];
        logic [11:0] e;
        ins   = '{I_ADD, I_SUB, I_SRAI};
        ex_ex = '{12'h004, 12'h00C, 12'h414};
        ex_wb = '{12'h284, 12'h28C, 12'h694};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            drive(ins[k], 1'b0);
            for (int c = 0; c < 5; c++) begin
                e = (c == 2) ? ex_ex[k] : (c == 3) ? ex_wb[k] : 12'h000;
                total_cnt++;
                if (o0 !== e) $display("FAIL alu_%h cyc%0d: got %h want %h", ins[k], c + 1, o0, e);
                else pass_cnt++;
                step();
            end
        end
    endtask

    task automatic test_lw();
        logic [11:0] e2 [8];
        logic [11:0] e0 [6];
        e2 = '{12'h000, 12'h000, 12'h404, 12'h444, 12'h444, 12'h444, 12'h784, 12'h000};
        e0 = '{12'h000, 12'h000, 12'h404, 12'h444, 12'h784, 12'h000};
        do_reset();
        drive(I_LW, 1'b0);
        for (int c = 0; c < 8; c++) begin
            total_cnt++;
            if (o2 !== e2[c]) $display("FAIL lw_wait2 cyc%0d: got %h want %h", c + 1, o2, e2[c]);
            else pass_cnt++;
            if (c < 6) begin
                total_cnt++;
                if (o0 !== e0[c]) $display("FAIL lw_wait0 cyc%0d: got %h want %h", c + 1, o0, e0[c]);
                else pass_cnt++;
            end
            step();
        end
    endtask

    task automatic test_sw();
        logic [11:0] e2 [7];
        logic [11:0] e0 [5];
        e2 = '{12'h000, 12'h000, 12'h404, 12'h404, 12'h404, 12'h4A4, 12'h000};
        e0 = '{12'h000, 12'h000, 12'h404, 12'h4A4, 12'h000};
        do_reset();
        drive(I_SW, 1'b0);
        for (int c = 0; c < 7; c++) begin
            total_cnt++;
            if (o2 !== e2[c]) $display("FAIL sw_wait2 cyc%0d: got %h want %h", c + 1, o2, e2[c]);
            else pass_cnt++;
            if (c < 5) begin
                total_cnt++;
                if (o0 !== e0[c]) $display("FAIL sw_wait0 cyc%0d: got %h want %h", c + 1, o0, e0[c]);
                else pass_cnt++;
            end
            step();
        end
    endtask

    task automatic test_beq();
        logic [11:0] e;
        for (int z = 1; z >= 0; z--) begin
            do_reset();
            drive(I_BEQ, 1'(z));
            for (int c = 0; c < 5; c++) begin
                e = (c == 2) ? 12'h00C : (c == 3) ? ((z == 1) ? 12'h88C : 12'h08C) : 12'h000;
                total_cnt++;
                if (o0 !== e) $display("FAIL beq_z%0d cyc%0d: got %h want %h", z, c + 1, o0, e);
                else pass_cnt++;
                step();
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ins [3];
        logic [11:0] e;
        ins = '{32'h00000000, 32'h402091B3, 32'h00003013};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            drive(ins[k], 1'b0);
            for (int c = 0; c < 5; c++) begin
                e = (c == 1 || c == 3) ? 12'h001 : 12'h000;
                total_cnt++;
                if (o0 !== e) $display("FAIL illegal_%h cyc%0d: got %h want %h", ins[k], c + 1, o0, e);
                else pass_cnt++;
                step();
            end
        end
    endtask

`ifdef CTRL_PERF_EN
    task automatic test_perf();
        logic [31:0] seq [3];
        seq = '{I_ADD, I_SW, I_BEQ};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(seq[k], 1'b1);
            for (int c = 0; c < 4; c++) step();
        end
        total_cnt++;
        if (if0.instret !== 32'd3) $display("FAIL perf_instret: got %0d want 3", if0.instret);
        else pass_cnt++;
        total_cnt++;
        if (if0.cycles !== 32'd12) $display("FAIL perf_cycles: got %0d want 12", if0.cycles);
        else pass_cnt++;
    endtask
`endif

    initial begin
        rst = 1'b0;
        drive(32'h0, 1'b0);
        test_reset();
        test_alu();
        test_lw();
        test_sw();
        test_beq();
        test_illegal();
`ifdef CTRL_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
